alu_system_control_unit: RTL and testbench

- Hardwired sequencer that drives every control input of the ALU datapath system: register file, address register file, ALU, instruction register, memory, and MUX A/B/C selects.
- Fetches a 16-bit instruction as two bytes (low, then high), executes it in one cycle, and repeats.
- It is the initiator for the datapath's control interface. It observes only IROut and FlagsOut.

---
 rtl/alu_system_control_unit.sv | 147 ++++++++++++++
 tb/tb_alu_system_control_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_system_control_unit.sv
// Hardwired sequencer for the ALU datapath system: two-byte instruction fetch
// followed by a single-cycle execute, with a sticky HALT exited only by Reset.
module alu_system_control_unit #(
  parameter logic [2:0] FS_LOAD   = 3'b010,
  parameter logic [2:0] FS_INC    = 3'b001,
  parameter logic [2:0] FS_CLR    = 3'b011,
  parameter logic [4:0] ALU_ADD   = 5'b10100,
  parameter logic [4:0] ALU_PASSA = 5'b10000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] IROut,
  input  logic [3:0]  FlagsOut,
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic [2:0]  RF_FunSel,
  output logic [3:0]  RF_RegSel,
  output logic [3:0]  RF_ScrSel,
  output logic [4:0]  ALU_FunSel,
  output logic        ALU_WF,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [2:0]  ARF_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic        IR_LH,
  output logic        IR_Write,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic        Halted,
  output logic [1:0]  T
);
  // state     | meaning
  // S_INIT    | clear PC
  // S_FETCH_L | read mem[PC] into IR low byte, PC++
  // S_FETCH_H | read mem[PC] into IR high byte, PC++
  // S_EXEC    | decode IROut and perform the instruction
  // S_HALT    | idle until Reset
  typedef enum logic [2:0] {
    S_INIT, S_FETCH_L, S_FETCH_H, S_EXEC, S_HALT
  } state_t;

  state_t     state, state_nxt;
  logic [5:0] op;
  logic [1:0] rd, rs;
  logic       flag_z;
  logic       unused_bits;

  assign op          = IROut[15:10];
  assign rd          = IROut[9:8];
  assign rs          = IROut[7:6];
  assign flag_z      = FlagsOut[3];
  // The branch target reaches PC through MuxB from the datapath, not through here.
  assign unused_bits = ^{IROut[5:0], FlagsOut[2:0]};

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= S_INIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    RF_OutASel  = 3'b000;
    RF_OutBSel  = 3'b000;
    RF_FunSel   = 3'b000;
    RF_RegSel   = 4'b0000;
    RF_ScrSel   = 4'b0000;
    ALU_FunSel  = 5'b00000;
    ALU_WF      = 1'b0;
    ARF_OutCSel = 2'b00;
    ARF_OutDSel = 2'b00;
    ARF_FunSel  = 3'b000;
    ARF_RegSel  = 3'b000;
    IR_LH       = 1'b0;
    IR_Write    = 1'b0;
    Mem_WR      = 1'b0;
    Mem_CS      = 1'b1;
    MuxASel     = 2'b00;
    MuxBSel     = 2'b00;
    MuxCSel     = 1'b0;
    Halted      = 1'b0;
    T           = 2'd0;
    case (state)
      S_INIT: begin
        T          = 2'd0;
        ARF_RegSel = 3'b100;
        ARF_FunSel = FS_CLR;
        state_nxt  = S_FETCH_L;
      end
      S_FETCH_L, S_FETCH_H: begin
        T           = (state == S_FETCH_L) ? 2'd1 : 2'd2;
        ARF_OutDSel = 2'b00;
        Mem_CS      = 1'b0;
        IR_Write    = 1'b1;
        IR_LH       = (state == S_FETCH_H);
        ARF_RegSel  = 3'b100;
        ARF_FunSel  = FS_INC;
        state_nxt   = (state == S_FETCH_L) ? S_FETCH_H : S_EXEC;
      end
      S_EXEC: begin
        T         = 2'd3;
        state_nxt = S_FETCH_L;
        case (op)
          6'h01: begin
            MuxASel   = 2'b11;
            RF_FunSel = FS_LOAD;
            RF_RegSel = 4'b1000 >> rd;
          end
          6'h02, 6'h05: begin
            // BNE falls through to NOP when the zero flag is set
            if (op == 6'h02 || !flag_z) begin
              MuxBSel    = 2'b11;
              ARF_FunSel = FS_LOAD;
              ARF_RegSel = 3'b100;
            end
          end
          6'h03: begin
            RF_OutASel = {1'b0, rd};
            RF_OutBSel = {1'b0, rs};
            ALU_FunSel = ALU_ADD;
            ALU_WF     = 1'b1;
            MuxASel    = 2'b00;
            RF_FunSel  = FS_LOAD;
            RF_RegSel  = 4'b1000 >> rd;
          end
          6'h04: begin
            RF_OutASel  = {1'b0, rd};
            ALU_FunSel  = ALU_PASSA;
            MuxCSel     = 1'b0;
            ARF_OutDSel = 2'b10;
            Mem_CS      = 1'b0;
            Mem_WR      = 1'b1;
          end
          6'h3F:   state_nxt = S_HALT;
          default: ;
        endcase
      end
      S_HALT: begin
        T      = 2'd3;
        Halted = 1'b1;
      end
      default: state_nxt = S_INIT;
    endcase
  end
endmodule

// File: tb/tb_alu_system_control_unit.sv
// Randomized self-checking bench for the control unit; a cycle-count phase
// model predicts the full control word every cycle.
module tb_alu_system_control_unit;
  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] IROut = 16'h0000;
  logic [3:0]  FlagsOut = 4'h0;
  logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
  logic [3:0]  RF_RegSel, RF_ScrSel;
  logic [4:0]  ALU_FunSel;
  logic        ALU_WF;
  logic [1:0]  ARF_OutCSel, ARF_OutDSel;
  logic [2:0]  ARF_FunSel, ARF_RegSel;
  logic        IR_LH, IR_Write, Mem_WR, Mem_CS;
  logic [1:0]  MuxASel, MuxBSel;
  logic        MuxCSel, Halted;
  logic [1:0]  T;

  typedef struct packed {
    logic [2:0] rf_a, rf_b, rf_fs;
    logic [3:0] rf_reg, rf_scr;
    logic [4:0] alu_fs;
    logic       alu_wf;
    logic [1:0] arf_c, arf_d;
    logic [2:0] arf_fs, arf_reg;
    logic       ir_lh, ir_wr, mem_wr, mem_cs;
    logic [1:0] mux_a, mux_b;
    logic       mux_c, halted;
    logic [1:0] t;
  } ctrl_t;

  localparam int P_INIT = 0, P_FL = 1, P_FH = 2, P_EX = 3, P_HALT = 4;

  ctrl_t act, exp_c;
  int    n_checks = 0;
  int    n_fail = 0;
  int    cyc = 0;
  bit    halted_m = 0;

  assign act = {RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel, ALU_FunSel, ALU_WF,
                ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel, IR_LH, IR_Write, Mem_WR,
                Mem_CS, MuxASel, MuxBSel, MuxCSel, Halted, T};

  alu_system_control_unit dut (
    .Clock(Clock), .Reset(Reset), .IROut(IROut), .FlagsOut(FlagsOut),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
    .RF_RegSel(RF_RegSel), .RF_ScrSel(RF_ScrSel), .ALU_FunSel(ALU_FunSel), .ALU_WF(ALU_WF),
    .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel),
    .ARF_RegSel(ARF_RegSel), .IR_LH(IR_LH), .IR_Write(IR_Write), .Mem_WR(Mem_WR),
    .Mem_CS(Mem_CS), .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel),
    .Halted(Halted), .T(T)
  );

  always #5 Clock = ~Clock;

  // Phase follows from cycles elapsed since reset: INIT, then FL/FH/EX repeating.
  function automatic int cur_phase();
    if (cyc == 0) return P_INIT;
    if (halted_m) return P_HALT;
    return ((cyc - 1) % 3) + 1;
  endfunction

  function automatic ctrl_t model(int ph, logic [15:0] ir, logic [3:0] fl);
    ctrl_t e;
    int    op, rd;
    e = '0;
    e.mem_cs = 1'b1;
    op = int'(ir[15:10]);
    rd = int'(ir[9:8]);
    case (ph)
      P_INIT: begin e.arf_reg = 3'b100; e.arf_fs = 3'b011; end
      P_FL, P_FH: begin
        e.t = 2'(ph); e.mem_cs = 1'b0; e.ir_wr = 1'b1; e.ir_lh = (ph == P_FH);
        e.arf_reg = 3'b100; e.arf_fs = 3'b001;
      end
      P_EX: begin
        e.t = 2'd3;
        if (op == 1) begin
          e.mux_a = 2'b11; e.rf_fs = 3'b010; e.rf_reg[3 - rd] = 1'b1;
        end else if (op == 2 || (op == 5 && fl[3] == 1'b0)) begin
          e.mux_b = 2'b11; e.arf_fs = 3'b010; e.arf_reg = 3'b100;
        end else if (op == 3) begin
          e.rf_a = 3'(rd); e.rf_b = 3'(ir[7:6]); e.alu_fs = 5'b10100; e.alu_wf = 1'b1;
          e.rf_fs = 3'b010; e.rf_reg[3 - rd] = 1'b1;
        end else if (op == 4) begin
          e.rf_a = 3'(rd); e.alu_fs = 5'b10000; e.arf_d = 2'b10; e.mem_cs = 1'b0;
          e.mem_wr = 1'b1;
        end
      end
      default: begin e.t = 2'd3; e.halted = 1'b1; end
    endcase
    return e;
  endfunction

  // Advance one clock, update the phase model, then drive the inputs for the new cycle.
  task automatic step(input logic [15:0] ir, input logic [3:0] fl);
    @(posedge Clock);
    if (Reset) begin
      if (cur_phase() == P_EX && IROut[15:10] == 6'h3F) halted_m = 1;
      cyc++;
    end
    #1;
    IROut = ir;
    FlagsOut = fl;
    #2;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(16'h0000, 4'h0);
      exp_c = model(P_INIT, IROut, FlagsOut);
      n_checks++;
      if (act !== exp_c) begin
        n_fail++;
        $display("FAIL reset_hold: got %h expected %h", act, exp_c);
      end
    end
    Reset = 1'b1;
    #1;
    n_checks++;
    if (ARF_RegSel !== 3'b100 || ARF_FunSel !== 3'b011 || T !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_init: got regsel %b funsel %b T %0d expected 100 011 0",
               ARF_RegSel, ARF_FunSel, T);
    end
  endtask

  task automatic test_fetch_nop();
    for (int i = 0; i < 6; i++) begin
      step(16'h0000, 4'h0);
      n_checks++;
      if (T !== 2'((i % 3) + 1) || act !== model(cur_phase(), IROut, FlagsOut)) begin
        n_fail++;
        $display("FAIL fetch_nop: got T %0d word %h expected T %0d word %h", T, act,
                 (i % 3) + 1, model(cur_phase(), IROut, FlagsOut));
      end
    end
  endtask

  task automatic test_ldi();
    for (int i = 0; i < 3; i++) step(16'h052A, 4'h0);
    n_checks++;
    if (MuxASel !== 2'b11 || RF_RegSel !== 4'b0100 || RF_FunSel !== 3'b010) begin
      n_fail++;
      $display("FAIL ldi: got muxa %b regsel %b funsel %b expected 11 0100 010",
               MuxASel, RF_RegSel, RF_FunSel);
    end
  endtask

  task automatic test_add();
    for (int i = 0; i < 3; i++) step(16'h0C40, 4'h0);
    n_checks++;
    if (RF_OutASel !== 3'd0 || RF_OutBSel !== 3'd1 || ALU_FunSel !== 5'b10100 ||
        ALU_WF !== 1'b1 || RF_RegSel !== 4'b1000) begin
      n_fail++;
      $display("FAIL add: got a %0d b %0d alu %b wf %b regsel %b expected 0 1 10100 1 1000",
               RF_OutASel, RF_OutBSel, ALU_FunSel, ALU_WF, RF_RegSel);
    end
  endtask

  task automatic test_bne();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) step(16'h1410, (k == 0) ? 4'b0000 : 4'b1000);
      exp_c = model(cur_phase(), IROut, FlagsOut);
      n_checks++;
      if (ARF_RegSel !== ((k == 0) ? 3'b100 : 3'b000) || act !== exp_c) begin
        n_fail++;
        $display("FAIL bne_z%0d: got regsel %b word %h expected word %h", k, ARF_RegSel,
                 act, exp_c);
      end
    end
  endtask

  task automatic test_halt();
    for (int i = 0; i < 3; i++) step(16'hFC00, 4'h0);
    for (int i = 0; i < 10; i++) begin
      step(16'(i * 16'h1111), 4'(i));
      n_checks++;
      if (Halted !== 1'b1 || Mem_CS !== 1'b1 || RF_RegSel !== 4'b0 || ARF_RegSel !== 3'b0 ||
          act !== model(P_HALT, IROut, FlagsOut)) begin
        n_fail++;
        $display("FAIL halt_hold%0d: got word %h expected %h", i, act,
                 model(P_HALT, IROut, FlagsOut));
      end
    end
  endtask

  task automatic test_reset_mid_fetch();
    Reset = 1'b0;
    cyc = 0;
    halted_m = 0;
    #1;
    n_checks++;
    if (Halted !== 1'b0 || T !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_from_halt: got halted %b T %0d expected 0 0", Halted, T);
    end
    step(16'h0000, 4'h0);
    Reset = 1'b1;
    step(16'h0000, 4'h0);
    step(16'h052A, 4'h0);
    n_checks++;
    if (T !== 2'd2 || IR_Write !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_abort: got T %0d irw %b expected 2 1", T, IR_Write);
    end
    Reset = 1'b0;
    cyc = 0;
    #1;
    exp_c = model(P_INIT, IROut, FlagsOut);
    n_checks++;
    if (IR_Write !== 1'b0 || act !== exp_c) begin
      n_fail++;
      $display("FAIL abort_fetch_h: got word %h expected %h", act, exp_c);
    end
    step(16'h0000, 4'h0);
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(16'h0000, 4'h0);
      exp_c = model(cur_phase(), IROut, FlagsOut);
      n_checks++;
      if (act !== exp_c) begin
        n_fail++;
        $display("FAIL restart%0d: got %h expected %h", i, act, exp_c);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] ir;
    logic [5:0]  op;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 7))
        0: op = 6'h00; 1: op = 6'h01; 2: op = 6'h02; 3: op = 6'h03;
        4: op = 6'h04; 5, 6: op = 6'h05;
        default: op = 6'($urandom_range(6, 62));
      endcase
      ir = {op, 10'($urandom())};
      for (int i = 0; i < 3; i++) begin
        step((i == 2) ? ir : 16'($urandom()), 4'($urandom()));
        exp_c = model(cur_phase(), IROut, FlagsOut);
        n_checks++;
        if (act !== exp_c) begin
          n_fail++;
          $display("FAIL random ir=%h fl=%b ph=%0d: got %h expected %h", IROut, FlagsOut,
                   cur_phase(), act, exp_c);
        end
      end
    end
  endtask

  initial begin
    #1;
    n_checks++;
    if (T !== 2'd0 || ARF_RegSel !== 3'b100 || IR_Write !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: got T %0d regsel %b irw %b expected 0 100 0", T,
               ARF_RegSel, IR_Write);
    end
    test_reset();
    test_fetch_nop();
    test_ldi();
    test_add();
    test_bne();
    test_random();
    test_halt();
    test_reset_mid_fetch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
